player_motion_ctrl: RTL and testbench

Parametrised per-frame movement and animation controller for N_PLAYERS sprites in the Bomberman video pipeline.
- Samples per-player direction buttons once per frame, on the rising edge of EOF.
- Moves each player by STEP pixels, saturated to the active screen area.
- Tracks facing direction and a walk-cycle phase, producing a 3-bit sprite index per player for the sprite renderer.

---
 rtl/bomber_pkg.sv | 17 +
 rtl/player_motion.sv | 113 +++++++++++
 rtl/player_motion_ctrl.sv | 70 +++++++
 tb/tb_player_motion_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomber_pkg.sv
// Shared types and helpers for the Bomberman sprite motion path.
package bomber_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } facing_t;

    function automatic logic [2:0] sprite_code(facing_t f, logic step);
        return {f, step};
    endfunction

endpackage

// File: rtl/player_motion.sv
// One player's position, facing and walk-cycle state, advanced once per frame tick.
module player_motion
    import bomber_pkg::*;
#(
    parameter int HACTIVE     = 800,
    parameter int VACTIVE     = 600,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int STEP        = 1,
    parameter int ANIM_FRAMES = 8,
    parameter int DIAGONAL    = 0,
    parameter int START_X     = 400,
    parameter int START_Y     = 300
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               enable,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [2:0]         sprite_num,
    output logic               moving
);

    localparam int PW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic signed [COORD_W:0] X_MAX  = (COORD_W+1)'(HACTIVE - SPRITE_W);
    localparam logic signed [COORD_W:0] Y_MAX  = (COORD_W+1)'(VACTIVE - SPRITE_H);
    localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(STEP);
    localparam logic [PW-1:0]           PHASE_LAST = PW'(ANIM_FRAMES - 1);

    facing_t                facing, facing_next;
    logic [PW-1:0]          phase, phase_next;
    logic                   step, step_next;
    logic                   v_req, h_req, do_h, moved;
    logic signed [COORD_W:0] x_try, y_try;
    logic [COORD_W-1:0]     x_next, y_next;

    // One guard bit above the coordinate width catches both underflow and overshoot.
    function automatic logic [COORD_W-1:0] clamp(logic signed [COORD_W:0] v,
                                                 logic signed [COORD_W:0] hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return COORD_W'(hi);
        else
            return COORD_W'(v);
    endfunction

    always_comb begin
        v_req = up ^ down;
        h_req = left ^ right;
        do_h  = h_req && ((DIAGONAL != 0) || !v_req);

        x_try = signed'({pos_x[COORD_W-1], pos_x});
        y_try = signed'({pos_y[COORD_W-1], pos_y});
        if (do_h)
            x_try = left ? x_try - STEP_S : x_try + STEP_S;
        if (v_req)
            y_try = up ? y_try - STEP_S : y_try + STEP_S;
        x_next = clamp(x_try, X_MAX);
        y_next = clamp(y_try, Y_MAX);
        moved  = (x_next != pos_x) || (y_next != pos_y);

        facing_next = facing;
        if (v_req)
            facing_next = up ? UP : DOWN;
        else if (h_req)
            facing_next = left ? LEFT : RIGHT;

        phase_next = '0;
        step_next  = 1'b0;
        if (moved) begin
            if (phase == PHASE_LAST) begin
                phase_next = '0;
                step_next  = ~step;
            end else begin
                phase_next = phase + PW'(1);
                step_next  = step;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x  <= COORD_W'(START_X);
            pos_y  <= COORD_W'(START_Y);
            facing <= DOWN;
            phase  <= '0;
            step   <= 1'b0;
            moving <= 1'b0;
        end else if (tick) begin
            if (enable) begin
                pos_x  <= x_next;
                pos_y  <= y_next;
                facing <= facing_next;
                phase  <= phase_next;
                step   <= step_next;
                moving <= moved;
            end else begin
                phase  <= '0;
                step   <= 1'b0;
                moving <= 1'b0;
            end
        end
    end

    assign sprite_num = sprite_code(facing, step);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame motion/animation controller: EOF edge detect plus one player_motion per sprite.
module player_motion_ctrl
    import bomber_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int HACTIVE     = 800,
    parameter int VACTIVE     = 600,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int STEP        = 1,
    parameter int ANIM_FRAMES = 8,
    parameter int DIAGONAL    = 0,
    parameter int START_X     = 400,
    parameter int START_DX    = 50,
    parameter int START_Y     = 300
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           eof,
    input  logic                           enable,
    input  logic [N_PLAYERS-1:0]           btn_up,
    input  logic [N_PLAYERS-1:0]           btn_down,
    input  logic [N_PLAYERS-1:0]           btn_left,
    input  logic [N_PLAYERS-1:0]           btn_right,
    output logic [N_PLAYERS*COORD_W-1:0]   pos_x,
    output logic [N_PLAYERS*COORD_W-1:0]   pos_y,
    output logic [N_PLAYERS*3-1:0]         sprite_num,
    output logic [N_PLAYERS-1:0]           moving,
    output logic                           frame_tick
);

    logic eof_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            eof_q <= 1'b0;
        else
            eof_q <= eof;
    end

    assign frame_tick = eof & ~eof_q;

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        player_motion #(
            .HACTIVE     (HACTIVE),
            .VACTIVE     (VACTIVE),
            .SPRITE_W    (SPRITE_W),
            .SPRITE_H    (SPRITE_H),
            .STEP        (STEP),
            .ANIM_FRAMES (ANIM_FRAMES),
            .DIAGONAL    (DIAGONAL),
            .START_X     (START_X + i * START_DX),
            .START_Y     (START_Y)
        ) u_player (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (frame_tick),
            .enable     (enable),
            .up         (btn_up[i]),
            .down       (btn_down[i]),
            .left       (btn_left[i]),
            .right      (btn_right[i]),
            .pos_x      (pos_x[COORD_W*i +: COORD_W]),
            .pos_y      (pos_y[COORD_W*i +: COORD_W]),
            .sprite_num (sprite_num[3*i +: 3]),
            .moving     (moving[i])
        );
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: three configurations driven in lockstep against a behavioural model.
module tb_player_motion_ctrl;

    localparam int ND = 3;
    localparam int NP = 2;
    localparam int AF = 8;

    logic clk = 1'b0;
    logic reset_n, eof, enable;
    logic [NP-1:0] up, down, left, right;
    logic [NP*11-1:0] px [ND];
    logic [NP*11-1:0] py [ND];
    logic [NP*3-1:0]  sn [ND];
    logic [NP-1:0]    mv [ND];
    logic             ft [ND];

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    int mx [ND][NP];
    int my [ND][NP];
    int mf [ND][NP];
    int mph[ND][NP];
    int mst[ND][NP];
    int mmv[ND][NP];

    always #5 clk = ~clk;

    // d0: defaults, d1: STEP=4, d2: DIAGONAL=1
    player_motion_ctrl #(.N_PLAYERS(NP)) dut0 (
        .clk(clk), .reset_n(reset_n), .eof(eof), .enable(enable),
        .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
        .pos_x(px[0]), .pos_y(py[0]), .sprite_num(sn[0]), .moving(mv[0]), .frame_tick(ft[0]));
    player_motion_ctrl #(.N_PLAYERS(NP), .STEP(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .eof(eof), .enable(enable),
        .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
        .pos_x(px[1]), .pos_y(py[1]), .sprite_num(sn[1]), .moving(mv[1]), .frame_tick(ft[1]));
    player_motion_ctrl #(.N_PLAYERS(NP), .DIAGONAL(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .eof(eof), .enable(enable),
        .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
        .pos_x(px[2]), .pos_y(py[2]), .sprite_num(sn[2]), .moving(mv[2]), .frame_tick(ft[2]));

    always @(posedge clk) if (ft[0]) tick_cnt <= tick_cnt + 1;

    function automatic int stp(int d); return (d == 1) ? 4 : 1; endfunction
    function automatic int dia(int d); return (d == 2) ? 1 : 0; endfunction
    function automatic int ox(int d, int p); return int'($signed(px[d][p*11 +: 11])); endfunction
    function automatic int oy(int d, int p); return int'($signed(py[d][p*11 +: 11])); endfunction
    function automatic int os(int d, int p); return int'(sn[d][p*3 +: 3]); endfunction
    function automatic int om(int d, int p); return int'(mv[d][p]); endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < NP; p++) begin
                mx[d][p] = 400 + 50 * p; my[d][p] = 300; mf[d][p] = 1;
                mph[d][p] = 0; mst[d][p] = 0; mmv[d][p] = 0;
            end
    endtask

    task automatic model_tick();
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < NP; p++) begin
                int vy, hx, nx, ny;
                if (!enable) begin
                    mph[d][p] = 0; mst[d][p] = 0; mmv[d][p] = 0;
                    continue;
                end
                vy = int'(down[p]) - int'(up[p]);
                hx = int'(right[p]) - int'(left[p]);
                if (vy < 0) mf[d][p] = 0;
                else if (vy > 0) mf[d][p] = 1;
                else if (hx < 0) mf[d][p] = 2;
                else if (hx > 0) mf[d][p] = 3;
                if (dia(d) == 0 && vy != 0) hx = 0;
                nx = mx[d][p] + hx * stp(d);
                ny = my[d][p] + vy * stp(d);
                nx = (nx < 0) ? 0 : ((nx > 768) ? 768 : nx);
                ny = (ny < 0) ? 0 : ((ny > 568) ? 568 : ny);
                mmv[d][p] = (nx != mx[d][p] || ny != my[d][p]) ? 1 : 0;
                mx[d][p] = nx; my[d][p] = ny;
                if (mmv[d][p] == 1) begin
                    if (mph[d][p] == AF - 1) begin
                        mph[d][p] = 0; mst[d][p] = 1 - mst[d][p];
                    end else
                        mph[d][p]++;
                end else begin
                    mph[d][p] = 0; mst[d][p] = 0;
                end
            end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; eof = 1'b0; enable = 1'b1;
        up = '0; down = '0; left = '0; right = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic frame(int hold);
        @(negedge clk);
        eof = 1'b1;
        model_tick();
        repeat (hold) @(negedge clk);
        eof = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (ox(d, p) !== 400 + 50 * p || oy(d, p) !== 300) begin
                    errors++;
                    $display("FAIL reset_pos d%0d p%0d: got (%0d,%0d) want (%0d,300)", d, p, ox(d, p), oy(d, p), 400 + 50 * p);
                end
                checks++;
                if (os(d, p) !== 2 || om(d, p) !== 0) begin
                    errors++;
                    $display("FAIL reset_sprite d%0d p%0d: got sprite %0d moving %0d want 2/0", d, p, os(d, p), om(d, p));
                end
            end
            checks++;
            if (ft[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_tick d%0d: got %b want 0", d, ft[d]);
            end
        end
    endtask

    task automatic test_walk();
        apply_reset();
        right = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            frame(1);
            checks++;
            if (ox(0, 0) !== 400 + k || om(0, 0) !== 1) begin
                errors++;
                $display("FAIL walk_x frame %0d: got x=%0d moving=%0d want x=%0d moving=1", k, ox(0, 0), om(0, 0), 400 + k);
            end
            checks++;
            if (os(0, 0) !== ((k >= 8) ? 7 : 6)) begin
                errors++;
                $display("FAIL walk_sprite frame %0d: got %0d want %0d", k, os(0, 0), (k >= 8) ? 7 : 6);
            end
            checks++;
            if (ox(1, 0) !== mx[1][0] || os(1, 0) !== mf[1][0] * 2 + mst[1][0]) begin
                errors++;
                $display("FAIL walk_step4 frame %0d: got x=%0d sprite=%0d want x=%0d sprite=%0d", k, ox(1, 0), os(1, 0), mx[1][0], mf[1][0] * 2 + mst[1][0]);
            end
        end
    endtask

    task automatic test_long_eof();
        int start;
        apply_reset();
        down = 2'b01;
        start = tick_cnt;
        frame(5);
        checks++;
        if (tick_cnt - start !== 1) begin
            errors++;
            $display("FAIL long_eof_ticks: got %0d want 1", tick_cnt - start);
        end
        checks++;
        if (oy(0, 0) !== 301 || ox(0, 0) !== 400) begin
            errors++;
            $display("FAIL long_eof_pos: got (%0d,%0d) want (400,301)", ox(0, 0), oy(0, 0));
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        right = 2'b10;
        repeat (79) frame(1);
        checks++;
        if (ox(1, 1) !== 766) begin
            errors++;
            $display("FAIL sat_pre_right: got %0d want 766", ox(1, 1));
        end
        frame(1);
        checks++;
        if (ox(1, 1) !== 768 || om(1, 1) !== 1) begin
            errors++;
            $display("FAIL sat_right: got x=%0d moving=%0d want 768/1", ox(1, 1), om(1, 1));
        end
        frame(1);
        checks++;
        if (ox(1, 1) !== 768 || om(1, 1) !== 0 || os(1, 1) !== 6) begin
            errors++;
            $display("FAIL sat_blocked_right: got x=%0d moving=%0d sprite=%0d want 768/0/6", ox(1, 1), om(1, 1), os(1, 1));
        end
        checks++;
        if (ox(0, 1) !== mx[0][1]) begin
            errors++;
            $display("FAIL sat_step1_peer: got %0d want %0d", ox(0, 1), mx[0][1]);
        end
        apply_reset();
        left = 2'b10;
        repeat (112) frame(1);
        checks++;
        if (ox(1, 1) !== 2) begin
            errors++;
            $display("FAIL sat_pre_left: got %0d want 2", ox(1, 1));
        end
        frame(1);
        checks++;
        if (ox(1, 1) !== 0 || om(1, 1) !== 1) begin
            errors++;
            $display("FAIL sat_left: got x=%0d moving=%0d want 0/1", ox(1, 1), om(1, 1));
        end
        frame(1);
        checks++;
        if (ox(1, 1) !== 0 || om(1, 1) !== 0 || os(1, 1) !== 4) begin
            errors++;
            $display("FAIL sat_blocked_left: got x=%0d moving=%0d sprite=%0d want 0/0/4", ox(1, 1), om(1, 1), os(1, 1));
        end
    endtask

    task automatic test_cancel();
        apply_reset();
        up = 2'b01; down = 2'b01; left = 2'b01;
        frame(1);
        for (int d = 0; d < ND; d += 2) begin
            checks++;
            if (ox(d, 0) !== 399 || oy(d, 0) !== 300 || os(d, 0) !== 4) begin
                errors++;
                $display("FAIL cancel_v d%0d: got (%0d,%0d) sprite %0d want (399,300) sprite 4", d, ox(d, 0), oy(d, 0), os(d, 0));
            end
        end
        right = 2'b01;
        frame(1);
        checks++;
        if (ox(2, 0) !== 399 || oy(2, 0) !== 300 || os(2, 0) !== 4 || om(2, 0) !== 0) begin
            errors++;
            $display("FAIL cancel_all_diag: got (%0d,%0d) sprite %0d moving %0d want (399,300) 4 0", ox(2, 0), oy(2, 0), os(2, 0), om(2, 0));
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            up = NP'($urandom); down = NP'($urandom); left = NP'($urandom); right = NP'($urandom);
            frame(1);
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < NP; p++) begin
                    checks++;
                    if (om(d, p) !== 0 || ox(d, p) !== mx[d][p] || os(d, p) !== mf[d][p] * 2) begin
                        errors++;
                        $display("FAIL enable_hold d%0d p%0d: got x=%0d moving=%0d sprite=%0d want x=%0d 0 %0d", d, p, ox(d, p), om(d, p), os(d, p), mx[d][p], mf[d][p] * 2);
                    end
                end
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            up = NP'($urandom); down = NP'($urandom); left = NP'($urandom); right = NP'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            frame($urandom_range(1, 3));
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < NP; p++) begin
                    checks++;
                    if (ox(d, p) !== mx[d][p] || oy(d, p) !== my[d][p] ||
                        os(d, p) !== mf[d][p] * 2 + mst[d][p] || om(d, p) !== mmv[d][p]) begin
                        errors++;
                        $display("FAIL random f%0d d%0d p%0d: got (%0d,%0d) s%0d m%0d want (%0d,%0d) s%0d m%0d",
                                 k, d, p, ox(d, p), oy(d, p), os(d, p), om(d, p),
                                 mx[d][p], my[d][p], mf[d][p] * 2 + mst[d][p], mmv[d][p]);
                    end
                end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        right = 2'b10;
        repeat (20) frame(1);
        checks++;
        if (ox(0, 1) !== 470 || os(0, 1) !== mf[0][1] * 2 + mst[0][1]) begin
            errors++;
            $display("FAIL pre_reset: got x=%0d sprite=%0d want 470/%0d", ox(0, 1), os(0, 1), mf[0][1] * 2 + mst[0][1]);
        end
        @(negedge clk);
        eof = 1'b1;
        #2;
        reset_n = 1'b0;
        eof = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (ox(d, 1) !== 450 || oy(d, 1) !== 300 || os(d, 1) !== 2 || om(d, 1) !== 0) begin
                errors++;
                $display("FAIL async_reset d%0d: got (%0d,%0d) s%0d m%0d want (450,300) s2 m0", d, ox(d, 1), oy(d, 1), os(d, 1), om(d, 1));
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        repeat (8) frame(1);
        checks++;
        if (ox(0, 1) !== 458 || os(0, 1) !== 7) begin
            errors++;
            $display("FAIL post_reset_anim: got x=%0d sprite=%0d want 458/7", ox(0, 1), os(0, 1));
        end
    endtask

    initial begin
        reset_n = 1'b0; eof = 1'b0; enable = 1'b1;
        up = '0; down = '0; left = '0; right = '0;
        test_reset();
        test_walk();
        test_long_eof();
        test_saturate();
        test_cancel();
        test_enable();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
